zigzagu_stream: RTL and testbench
=================================

// Module: zigzagu_stream
// PURPOSE
//  Parametrised zig-zag address generator for bit-serial multiply. Walks the pw x pd bit-plane
//  grid by anti-diagonal s=w+d, ascending s. Within a diagonal, d ascends and w descends.
//  Emits one (offw,offd) term per valid/ready beat, repeated for ntile tiles.
//  Sits between the MVU controller (start/done) and the weight/data bit-plane address adders + shift-accumulator.
// PARAMETERS
//  BWP  4   precision / offset width; pw,pd in 1..2^BWP-1
//  BWT  16  tile-count width; ntile in 1..2^BWT-1
// PORTS
//  clk       in   1    clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  clr       in   1    synchronous abort to IDLE; highest priority after rst_n
//  start     in   1    start request; honoured only in IDLE
//  pw, pd    in   BWP  weight/data precision; sampled on accepted start
//  ntile     in   BWT  tile repeat count; sampled on accepted start
//  sgnw,sgnd in   1    operand is two's complement; sampled on accepted start (ZIGZAGU_SIGNED_EN only)
//  busy      out  1    state==RUN
//  done      out  1    1-cycle pulse after final handshake
//  cfg_err   out  1    1-cycle pulse: start seen in IDLE with pw==0, pd==0 or ntile==0
//  o_valid   out  1    term valid
//  o_ready   in   1    downstream accepts term
//  offw,offd out  BWP  bit-plane offsets of current term
//  o_tfirst  out  1    first term of tile; accumulator clears
//  o_first   out  1    first term of a diagonal; accumulator shifts (1 whenever o_tfirst)
//  o_dlast   out  1    last term of a diagonal
//  o_tlast   out  1    last term of tile
//  o_last    out  1    last term of last tile
//  o_tile    out  BWT  current tile index
//  o_neg     out  1    term carries negative weight (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=IDLE
//   - all outputs 0: busy, done, cfg_err, o_valid, offw, offd, flags, o_tile, o_neg
//  All outputs registered.
//  IDLE:
//   - start with a legal config: capture config; next edge enters RUN with o_valid=1,
//     (w,d)=(0,0), o_tile=0. Start-to-first-valid latency = 1 cycle.
//   - start with an illegal config: ignored; cfg_err pulses; stay IDLE.
//  RUN:
//   - o_valid held at 1. Outputs stable while o_ready=0.
//   - start is ignored. Config inputs are not sampled.
//   - Advance only on o_valid & o_ready.
//  Per-diagonal bounds: dmin(s)=max(0,s-pw+1), dmax(s)=min(s,pd-1), smax=pw+pd-2.
//  Advance rule, evaluated in order:
//   1. d<dmax(s): d++, w--.
//   2. else if s<smax: s++; d=dmin(s+1); w=s+1-d.
//   3. else if tile<ntile-1: tile++; (w,d)=(0,0).
//   4. else: go to IDLE; o_valid=0 and done=1 on the same edge.
//  Each tile emits exactly pw*pd terms. Every term of the grid is emitted exactly once.
//  Flags are combinational in (s,d,tile), registered with the offsets:
//   - o_first = (d==dmin(s))
//   - o_dlast = (d==dmax(s))
//   - o_tfirst = (s==0)
//   - o_tlast = (s==smax)
//   - o_last = o_tlast & (tile==ntile-1)
//  Simultaneous events:
//   - A start in the done cycle (state already IDLE) is accepted. Back-to-back ops leave one bubble.
//   - clr in any state: IDLE next edge, o_valid=0, no done pulse; any start in the same cycle is dropped.
//   - rst_n deasserted mid-run: same as clr, but asynchronous.
//  Width rules:
//   - s held in BWP+1 bits; smax up to 2^(BWP+1)-4.
//   - offsets never exceed pw-1 / pd-1.
// CONFIGURATION
//  ZIGZAGU_SIGNED_EN defined:
//   - sgnw and sgnd are captured at start.
//   - o_neg = (sgnw & offw==pw-1) ^ (sgnd & offd==pd-1), i.e. MSB-plane terms subtract.
//  ZIGZAGU_SIGNED_EN undefined:
//   - sgnw and sgnd are ignored.
//   - o_neg is tied to 0.
// TESTING
//  T1 pw=3,pd=2,ntile=1,o_ready=1:
//   - (w,d) sequence = (0,0)(1,0)(0,1)(2,0)(1,1)(2,1)
//   - o_first on beats 1,2,4,6; o_dlast on beats 1,3,5,6
//   - o_last on beat 6; done on the next cycle
//  T2 T1 config with o_ready pattern 1,0,0,1,0,1...:
//   - same 6-term sequence
//   - offsets and flags unchanged during every ready=0 cycle
//  T3 pw=1,pd=1,ntile=3:
//   - three beats of (0,0), each with o_tfirst=o_first=o_dlast=o_tlast=1
//   - o_tile = 0,1,2; o_last only on the third beat
//  T4 pw=15,pd=15,ntile=2:
//   - 450 beats; every tile ends at (14,14)
//   - every grid point hit exactly once per tile (scoreboard)
//  T5 Abort and bad config:
//   - clr at beat 3 of T1: o_valid=0 next cycle, no done
//   - rst_n pulse mid-run: outputs 0 immediately
//   - start with pd=0: cfg_err=1, busy stays 0
//  T6 ZIGZAGU_SIGNED_EN, pw=2,pd=2,sgnw=sgnd=1:
//   - (0,0)o_neg=0, (1,0)o_neg=1, (0,1)o_neg=1, (1,1)o_neg=0
//   - without the macro, o_neg=0 throughout

Source files
------------

// File: rtl/zigzagu_stream.sv
// Zig-zag bit-plane address generator for bit-serial multiply.
// Define ZIGZAGU_SIGNED_EN to enable signed MSB-plane negation (o_neg).
module zigzagu_stream #(
  parameter int BWP = 4,
  parameter int BWT = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           start,
  input  logic [BWP-1:0] pw,
  input  logic [BWP-1:0] pd,
  input  logic [BWT-1:0] ntile,
  input  logic           sgnw,
  input  logic           sgnd,
  output logic           busy,
  output logic           done,
  output logic           cfg_err,
  output logic           o_valid,
  input  logic           o_ready,
  output logic [BWP-1:0] offw,
  output logic [BWP-1:0] offd,
  output logic           o_tfirst,
  output logic           o_first,
  output logic           o_dlast,
  output logic           o_tlast,
  output logic           o_last,
  output logic [BWT-1:0] o_tile,
  output logic           o_neg
);

  localparam int SW = BWP + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [BWP-1:0] pw_q, pw_d, pd_q, pd_d;
  logic [BWT-1:0] nt_q, nt_d, t_q, t_d;
  logic           sw_q, sw_d, sd_q, sd_d;
  logic [SW-1:0]  s_q, s_d, s1, dm;
  logic [BWP-1:0] d_q, d_d, w_q, w_d;
  logic           done_q, done_d, err_q, err_d;
  logic [4:0]     fl_q, fl_d;
  logic           neg_q, neg_d;
  logic [SW-1:0]  smax_q, smax_d;
  logic           run_d;

  function automatic logic [SW-1:0] dmin_f(
    input logic [SW-1:0] s, input logic [BWP-1:0] p);
    logic [SW-1:0] px;
    px = {1'b0, p};
    return (s >= px) ? s - px + SW'(1) : '0;
  endfunction

  function automatic logic [SW-1:0] dmax_f(
    input logic [SW-1:0] s, input logic [BWP-1:0] p);
    logic [SW-1:0] pm;
    pm = {1'b0, p} - SW'(1);
    return (s < pm) ? s : pm;
  endfunction

  assign smax_q = {1'b0, pw_q} + {1'b0, pd_q} - SW'(2);

  always_comb begin
    state_d = state_q;
    pw_d = pw_q; pd_d = pd_q; nt_d = nt_q;
    sw_d = sw_q; sd_d = sd_q;
    s_d = s_q; d_d = d_q; w_d = w_q; t_d = t_q;
    done_d = 1'b0;
    err_d = 1'b0;
    s1 = s_q + SW'(1);
    dm = dmin_f(s1, pw_q);
    if (clr) begin
      state_d = IDLE;
      s_d = '0; d_d = '0; w_d = '0; t_d = '0;
    end else if (state_q == IDLE) begin
      if (start) begin
        if (pw == '0 || pd == '0 || ntile == '0) begin
          err_d = 1'b1;
        end else begin
          state_d = RUN;
          pw_d = pw; pd_d = pd; nt_d = ntile;
`ifdef ZIGZAGU_SIGNED_EN
          sw_d = sgnw; sd_d = sgnd;
`else
          sw_d = 1'b0; sd_d = 1'b0;
`endif
          s_d = '0; d_d = '0; w_d = '0; t_d = '0;
        end
      end
    end else if (o_ready) begin
      if ({1'b0, d_q} < dmax_f(s_q, pd_q)) begin
        d_d = d_q + BWP'(1);
        w_d = w_q - BWP'(1);
      end else if (s_q < smax_q) begin
        s_d = s1;
        d_d = dm[BWP-1:0];
        w_d = BWP'(s1 - dm);
      end else if (t_q < nt_q - BWT'(1)) begin
        t_d = t_q + BWT'(1);
        s_d = '0; d_d = '0; w_d = '0;
      end else begin
        state_d = IDLE;
        done_d = 1'b1;
        s_d = '0; d_d = '0; w_d = '0; t_d = '0;
      end
    end
    // Flags follow the term about to be presented; zero when idle.
    run_d = (state_d == RUN);
    smax_d = {1'b0, pw_d} + {1'b0, pd_d} - SW'(2);
    fl_d = '0;
    neg_d = 1'b0;
    if (run_d) begin
      fl_d = {s_d == '0,
              {1'b0, d_d} == dmin_f(s_d, pw_d),
              {1'b0, d_d} == dmax_f(s_d, pd_d),
              s_d == smax_d,
              (s_d == smax_d) && (t_d == nt_d - BWT'(1))};
      neg_d = (sw_d & (w_d == pw_d - BWP'(1)))
            ^ (sd_d & (d_d == pd_d - BWP'(1)));
    end
  end

`ifndef ZIGZAGU_SIGNED_EN
  logic unused_sgn;
  assign unused_sgn = sgnw ^ sgnd;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pw_q <= '0; pd_q <= '0; nt_q <= '0;
      sw_q <= 1'b0; sd_q <= 1'b0;
      s_q <= '0; d_q <= '0; w_q <= '0; t_q <= '0;
      done_q <= 1'b0; err_q <= 1'b0;
      fl_q <= '0; neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q <= pw_d; pd_q <= pd_d; nt_q <= nt_d;
      sw_q <= sw_d; sd_q <= sd_d;
      s_q <= s_d; d_q <= d_d; w_q <= w_d; t_q <= t_d;
      done_q <= done_d; err_q <= err_d;
      fl_q <= fl_d; neg_q <= neg_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign o_valid  = (state_q == RUN);
  assign done     = done_q;
  assign cfg_err  = err_q;
  assign offw     = w_q;
  assign offd     = d_q;
  assign o_tile   = t_q;
  assign o_tfirst = fl_q[4];
  assign o_first  = fl_q[3];
  assign o_dlast  = fl_q[2];
  assign o_tlast  = fl_q[1];
  assign o_last   = fl_q[0];
  assign o_neg    = neg_q;

endmodule

// File: tb/tb_zigzagu_stream.sv
// Directed bench for zigzagu_stream.
// Define ZIGZAGU_SIGNED_EN to expect signed o_neg terms.
module tb_zigzagu_stream;

  logic        clk, rst_n, clr, start;
  logic [3:0]  pw, pd;
  logic [15:0] ntile;
  logic        sgnw, sgnd;
  logic        busy, done, cfg_err, o_valid, o_ready;
  logic [3:0]  offw, offd;
  logic        o_tfirst, o_first, o_dlast, o_tlast, o_last;
  logic [15:0] o_tile;
  logic        o_neg;

  zigzagu_stream dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
    .pw(pw), .pd(pd), .ntile(ntile),
    .sgnw(sgnw), .sgnd(sgnd),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .o_valid(o_valid), .o_ready(o_ready),
    .offw(offw), .offd(offd),
    .o_tfirst(o_tfirst), .o_first(o_first),
    .o_dlast(o_dlast), .o_tlast(o_tlast),
    .o_last(o_last), .o_tile(o_tile), .o_neg(o_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] snap();
    return {offw, offd, o_tfirst, o_first, o_dlast,
            o_tlast, o_last, o_tile, o_neg};
  endfunction

  function automatic logic [29:0] mk(input int w, input int d,
    input logic [4:0] f, input int t, input logic n);
    return {4'(w), 4'(d), f, 16'(t), n};
  endfunction

  logic [29:0] qb[$];
  logic        done_seen;
  bit          pat[6] = '{1, 0, 0, 1, 0, 1};

  task automatic run_op(input int p_w, input int p_d, input int nt,
                        input logic sg, input bit stall,
                        input int budget, input string tg);
    logic [29:0] cur, hold_v;
    bit hold, fin;
    pw = 4'(p_w); pd = 4'(p_d); ntile = 16'(nt);
    sgnw = sg; sgnd = sg;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tg, "_lat"}, o_valid, 1'b1);
    qb.delete();
    done_seen = 1'b0;
    hold = 0; fin = 0;
    for (int c = 0; c < budget; c++) begin
      o_ready = stall ? pat[c % 6] : 1'b1;
      cur = snap();
      if (hold) chk({tg, "_hold"}, cur, hold_v);
      hold = 0;
      if (!o_valid) begin
        done_seen = done;
        fin = 1;
        break;
      end
      if (o_ready) qb.push_back(cur);
      else begin
        hold_v = cur;
        hold = 1;
      end
      @(negedge clk);
    end
    if (!fin) chk({tg, "_timeout"}, 0, 1);
    o_ready = 1'b1;
  endtask

  int t1w[6] = '{0, 1, 0, 2, 1, 2};
  int t1d[6] = '{0, 0, 1, 0, 1, 1};
  logic [4:0] t1f[6] = '{5'b11100, 5'b01000, 5'b00100,
                         5'b01000, 5'b00100, 5'b01111};

  task automatic chk_t1(input string tg);
    chk({tg, "_n"}, qb.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < qb.size())
        chk($sformatf("%s_b%0d", tg, i + 1), qb[i],
            mk(t1w[i], t1d[i], t1f[i], 0, 1'b0));
    chk({tg, "_done"}, done_seen, 1'b1);
  endtask

  int hit[2][16][16];

  initial begin
    int bad, ordv, tl_ok, tl_n, lst_n, ps, pdv;
    rst_n = 1'b0; clr = 1'b0; start = 1'b0;
    pw = '0; pd = '0; ntile = '0;
    sgnw = 1'b0; sgnd = 1'b0; o_ready = 1'b1;
    #12;
    chk("reset", {busy, done, cfg_err, o_valid, snap()}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // T1 and T2 back-to-back: start lands in the done cycle
    run_op(3, 2, 1, 1'b0, 1'b0, 40, "t1");
    chk_t1("t1");
    run_op(3, 2, 1, 1'b0, 1'b1, 80, "t2");
    chk_t1("t2");

    run_op(1, 1, 3, 1'b0, 1'b0, 40, "t3");
    chk("t3_n", qb.size(), 3);
    if (qb.size() == 3) begin
      chk("t3_b1", qb[0], mk(0, 0, 5'b11110, 0, 1'b0));
      chk("t3_b2", qb[1], mk(0, 0, 5'b11110, 1, 1'b0));
      chk("t3_b3", qb[2], mk(0, 0, 5'b11111, 2, 1'b0));
    end

    run_op(15, 15, 2, 1'b0, 1'b0, 600, "t4");
    chk("t4_n", qb.size(), 450);
    foreach (hit[t, w, d]) hit[t][w][d] = 0;
    ordv = 0; tl_ok = 0; tl_n = 0; lst_n = 0;
    ps = -1; pdv = -1;
    foreach (qb[i]) begin
      int w, d, t, s;
      w = int'(qb[i][29:26]);
      d = int'(qb[i][25:22]);
      t = int'(qb[i][16:1]);
      s = w + d;
      if (t < 2) hit[t][w][d]++;
      else ordv++;
      if (qb[i][21]) begin ps = -1; pdv = -1; end
      if (s < ps || (s == ps && d <= pdv)) ordv++;
      ps = s; pdv = d;
      if (qb[i][18]) begin
        tl_n++;
        if (w == 14 && d == 14) tl_ok++;
      end
      if (qb[i][17]) lst_n++;
    end
    bad = 0;
    foreach (hit[t, w, d])
      if (w < 15 && d < 15 && hit[t][w][d] != 1) bad++;
    chk("t4_grid", bad, 0);
    chk("t4_order", ordv, 0);
    chk("t4_tlast", {16'(tl_n), 16'(tl_ok)}, {16'd2, 16'd2});
    chk("t4_last_n", lst_n, 1);
    if (qb.size() == 450) chk("t4_last_pos", qb[449][17], 1'b1);
    chk("t4_done", done_seen, 1'b1);

    // T5 clr on beat 3
    @(negedge clk);
    pw = 4'd3; pd = 4'd2; ntile = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_b3", {o_valid, offw, offd}, {1'b1, 4'd0, 4'd1});
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_clr", {o_valid, busy, done}, 3'b000);
    @(negedge clk);
    chk("t5_nodone", {o_valid, done}, 2'b00);

    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    clr = 1'b0; start = 1'b0;
    chk("t5_clrstart", {busy, cfg_err}, 2'b00);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("t5_run", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("t5_rst", {busy, done, cfg_err, o_valid, snap()}, '0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t5_rst_idle", busy, 1'b0);

    pd = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_cfgerr", {cfg_err, busy}, 2'b10);
    @(negedge clk);
    chk("t5_cfgerr_pulse", {cfg_err, busy}, 2'b00);

    // T6 signed MSB planes
    run_op(2, 2, 1, 1'b1, 1'b0, 40, "t6");
    chk("t6_n", qb.size(), 4);
    if (qb.size() == 4) begin
`ifdef ZIGZAGU_SIGNED_EN
      chk("t6_b1", qb[0], mk(0, 0, 5'b11100, 0, 1'b0));
      chk("t6_b2", qb[1], mk(1, 0, 5'b01000, 0, 1'b1));
      chk("t6_b3", qb[2], mk(0, 1, 5'b00100, 0, 1'b1));
      chk("t6_b4", qb[3], mk(1, 1, 5'b01111, 0, 1'b0));
`else
      chk("t6_b1", qb[0], mk(0, 0, 5'b11100, 0, 1'b0));
      chk("t6_b2", qb[1], mk(1, 0, 5'b01000, 0, 1'b0));
      chk("t6_b3", qb[2], mk(0, 1, 5'b00100, 0, 1'b0));
      chk("t6_b4", qb[3], mk(1, 1, 5'b01111, 0, 1'b0));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
